rr_sample_arbiter: RTL and testbench

RR_SAMPLE_ARBITER -- requirements
Module: rr_sample_arbiter

---
 rtl/rr_sample_arbiter.sv | 117 +++++++++++
 tb/tb_rr_sample_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_sample_arbiter
// Purpose  : Round-robin arbiter sharing one fixed-latency datapath among
//            four sample channels, returning per-channel results.
// Revision : 1.0 - initial release
// ============================================================================
module rr_sample_arbiter #(
    parameter int NUMBITS = 14,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           chan_mask,
    input  logic [3:0]           req_valid,
    input  logic [4*NUMBITS-1:0] req_data,
    output logic [3:0]           req_ready,
    output logic                 dp_valid,
    output logic [NUMBITS-1:0]   dp_data,
    output logic [1:0]           dp_chan,
    input  logic [NUMBITS-1:0]   res_data,
    output logic [3:0]           out_valid,
    output logic [4*NUMBITS-1:0] out_data,
    input  logic [3:0]           out_ready,
    output logic                 busy
);

    logic [1:0]           r_ptr;
    logic [3:0]           r_inflight;
    logic                 r_dp_valid;
    logic [NUMBITS-1:0]   r_dp_data;
    logic [1:0]           r_dp_chan;
    logic [LATENCY-1:0]   r_tag_v;
    logic [1:0]           r_tag_c [LATENCY];
    logic [3:0]           r_out_valid;
    logic [4*NUMBITS-1:0] r_out_data;

    logic [3:0]           w_elig;
    logic [3:0]           w_gnt;
    logic                 w_gnt_any;
    logic [1:0]           w_gnt_idx;
    logic [1:0]           w_scan;
    logic                 w_emerge_v;
    logic [1:0]           w_emerge_c;
    logic [3:0]           w_cap;

    // A channel with a result waiting or a request outstanding is never
    // eligible, which also keeps it out of the grant on its out handshake.
    always_comb begin
        w_elig    = {4{enable & ~reset}} & chan_mask & req_valid
                    & ~r_inflight & ~r_out_valid;
        w_gnt_any = 1'b0;
        w_gnt_idx = r_ptr;
        w_scan    = r_ptr;
        // Scan from farthest to nearest so the closest eligible wins.
        for (int k = 3; k >= 0; k--) begin
            w_scan = r_ptr + 2'(k);
            if (w_elig[w_scan]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_scan;
            end
        end
        w_gnt = w_gnt_any ? (4'b0001 << w_gnt_idx) : 4'b0000;
    end

    assign w_emerge_v = r_tag_v[LATENCY-1];
    assign w_emerge_c = r_tag_c[LATENCY-1];
    assign w_cap      = w_emerge_v ? (4'b0001 << w_emerge_c) : 4'b0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= 2'd0;
            r_inflight  <= 4'd0;
            r_dp_valid  <= 1'b0;
            r_dp_data   <= '0;
            r_dp_chan   <= 2'd0;
            r_tag_v     <= '0;
            for (int j = 0; j < LATENCY; j++) begin
                r_tag_c[j] <= 2'd0;
            end
            r_out_valid <= 4'd0;
            r_out_data  <= '0;
        end else begin
            r_dp_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_dp_data <= req_data[w_gnt_idx*NUMBITS +: NUMBITS];
                r_dp_chan <= w_gnt_idx;
                r_ptr     <= w_gnt_idx + 2'd1;
            end

            // Tags follow the issued strobe so they line up with res_data.
            r_tag_v[0] <= r_dp_valid;
            r_tag_c[0] <= r_dp_chan;
            for (int j = LATENCY - 1; j > 0; j--) begin
                r_tag_v[j] <= r_tag_v[j-1];
                r_tag_c[j] <= r_tag_c[j-1];
            end

            r_inflight  <= (r_inflight | w_gnt) & ~w_cap;
            r_out_valid <= (r_out_valid & ~out_ready) | w_cap;
            if (w_emerge_v) begin
                r_out_data[w_emerge_c*NUMBITS +: NUMBITS] <= res_data;
            end
        end
    end

    assign req_ready = w_gnt;
    assign dp_valid  = r_dp_valid;
    assign dp_data   = r_dp_data;
    assign dp_chan   = r_dp_chan;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = ~reset & ((|r_inflight) | (|r_out_valid));

endmodule
`default_nettype wire

// File: tb/tb_rr_sample_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_sample_arbiter
// Purpose  : Directed self-checking bench; datapath stand-in returns data+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_sample_arbiter;

    localparam int NB  = 14;
    localparam int LAT = 3;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [3:0]      chan_mask;
    logic [3:0]      req_valid;
    logic [4*NB-1:0] req_data;
    logic [3:0]      req_ready;
    logic            dp_valid;
    logic [NB-1:0]   dp_data;
    logic [1:0]      dp_chan;
    logic [NB-1:0]   res_data;
    logic [3:0]      out_valid;
    logic [4*NB-1:0] out_data;
    logic [3:0]      out_ready;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_sample_arbiter #(.NUMBITS(NB), .LATENCY(LAT)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .chan_mask (chan_mask),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dp_valid  (dp_valid),
        .dp_data   (dp_data),
        .dp_chan   (dp_chan),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared datapath stand-in: result = data + 1, LAT cycles after issue.
    logic [NB-1:0] r_pipe [LAT];
    always @(posedge clk) begin
        r_pipe[0] <= dp_data + 14'd1;
        for (int j = 1; j < LAT; j++) r_pipe[j] <= r_pipe[j-1];
    end
    assign res_data = r_pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB-1:0] od(input int c);
        return out_data[c*NB +: NB];
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        chan_mask = 4'h0;
        req_valid = 4'h0;
        out_ready = 4'h0;
        step();
        step();
        check_eq("rst_dp_valid",  dp_valid,  0);
        check_eq("rst_dp_data",   dp_data,   0);
        check_eq("rst_dp_chan",   dp_chan,   0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data",  out_data,  0);
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_req_ready", req_ready, 0);
        reset = 1'b0;
    endtask

    logic [3:0] exp_rdy [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4};
    int g_cnt [4];
    int hold_err;
    int dp_cnt;

    initial begin
        reset    = 1'b1;
        req_data = {14'h3FFF, 14'h1234, 14'h2001, 14'h0ABC};

        // All channels requesting: strict 0,1,2,3 rotation, re-grant only after handshake
        do_reset();
        enable = 1'b1; chan_mask = 4'hF; req_valid = 4'hF; out_ready = 4'hF;
        for (int k = 0; k < 9; k++) begin
            #1;
            check_eq($sformatf("rr_ready_c%0d", k), req_ready, exp_rdy[k]);
            if (k == 1) begin
                check_eq("rr_dp_chan0", dp_chan, 0);
                check_eq("rr_dp_data0", dp_data, 14'h0ABC);
            end
            if (k == 5) begin
                check_eq("rr_out_valid5", out_valid, 4'h1);
                check_eq("rr_out_data0", od(0), 14'h0ABD);
            end
            if (k == 8) begin
                check_eq("rr_out_valid8", out_valid, 4'h8);
                check_eq("rr_out_data3_wrap", od(3), 14'h0000);
            end
            step();
        end

        // Single request on channel 2
        do_reset();
        enable = 1'b1; chan_mask = 4'hF; req_valid = 4'h4; out_ready = 4'hF;
        #1;
        check_eq("single_ready", req_ready, 4'h4);
        step();
        req_valid = 4'h0;
        #1;
        check_eq("single_dp_valid", dp_valid, 1);
        check_eq("single_dp_chan",  dp_chan,  2);
        check_eq("single_dp_data",  dp_data,  14'h1234);
        check_eq("single_busy",     busy,     1);
        for (int k = 2; k < 5; k++) begin
            step(); #1;
            check_eq($sformatf("single_no_out_c%0d", k), out_valid, 0);
        end
        step(); #1;
        check_eq("single_out_valid", out_valid, 4'h4);
        check_eq("single_out_data",  od(2),     14'h1235);
        step(); #1;
        check_eq("single_out_clear", out_valid, 0);
        check_eq("single_busy_end",  busy,      0);

        // Backpressure on channel 1
        do_reset();
        enable = 1'b1; chan_mask = 4'hF; req_valid = 4'hF; out_ready = 4'hD;
        for (int i = 0; i < 4; i++) g_cnt[i] = 0;
        hold_err = 0;
        for (int k = 0; k < 30; k++) begin
            #1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g_cnt[i]++;
            if (k >= 6 && (out_valid[1] !== 1'b1 || od(1) !== 14'h2002)) hold_err++;
            step();
        end
        check_eq("bp_ch1_grants", g_cnt[1], 1);
        check_eq("bp_hold_errs",  hold_err, 0);
        check_eq("bp_ch0_cycles", g_cnt[0] >= 3, 1);
        check_eq("bp_ch2_cycles", g_cnt[2] >= 3, 1);
        check_eq("bp_ch3_cycles", g_cnt[3] >= 3, 1);

        // Enable dropped after grants to channels 0 and 1
        do_reset();
        enable = 1'b1; chan_mask = 4'hF; req_valid = 4'h3; out_ready = 4'hF;
        #1;
        check_eq("en_ready0", req_ready, 4'h1);
        step(); #1;
        check_eq("en_ready1", req_ready, 4'h2);
        step();
        enable = 1'b0;
        #1;
        check_eq("en_ready_off", req_ready, 4'h0);
        check_eq("en_dp_chan1",  dp_chan,   1);
        dp_cnt = 0;
        for (int k = 3; k <= 8; k++) begin
            step(); #1;
            if (dp_valid) dp_cnt++;
            if (k == 5) check_eq("en_out0", out_valid, 4'h1);
            if (k == 6) begin
                check_eq("en_out1", out_valid, 4'h2);
                check_eq("en_busy6", busy, 1);
            end
            if (k == 7) check_eq("en_busy7", busy, 0);
        end
        check_eq("en_no_dp", dp_cnt, 0);

        // Reset while channel 3 is in flight
        do_reset();
        enable = 1'b1; chan_mask = 4'hF; req_valid = 4'h8; out_ready = 4'hF;
        #1;
        check_eq("rf_ready3", req_ready, 4'h8);
        step();
        req_valid = 4'h0;
        step();
        reset = 1'b1;
        #1;
        check_eq("rf_busy_in_reset",  busy,      0);
        check_eq("rf_ready_in_reset", req_ready, 0);
        step();
        step();
        reset = 1'b0;
        for (int k = 4; k < 10; k++) begin
            #1;
            check_eq($sformatf("rf_out_valid_c%0d", k), out_valid, 0);
            check_eq($sformatf("rf_busy_c%0d", k), busy, 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
